rs232_tx_ctrl: RTL and testbench
================================

// Module: rs232_tx_ctrl
// PURPOSE
//  Upstream timing/control stage of the RS-232 transmitter. Accepts a byte via
//  ready/request handshake, generates baud timing, and drives the frame-active
//  flag, bit index (0=start, 1..8=data LSB first, 9=stop) and held data byte.
//  These feed the downstream bit-mux stage that drives the TX pin.
// PARAMETERS
//  CLK_FREQ   50_000_000  clk_ref frequency in Hz
//  BAUD       115200      line rate in bit/s
//  BAUD_DIV   CLK_FREQ/BAUD (localparam, truncated) clocks per bit; must be 2..65535
// PORTS
//  clk_ref       in   1  system clock
//  rst_n         in   1  reset, asynchronous, active-low
//  i_tx_req      in   1  byte request; transfer when i_tx_req & o_tx_rdy at posedge
//  i_tx_dat      in   8  byte to send; sampled only on transfer cycle
//  o_tx_rdy      out  1  high in IDLE; able to accept a byte
//  o_rs232_busy  out  1  high for entire 10-bit frame
//  o_ctrl_cnt    out  4  current bit index 0..9, valid while busy
//  o_tx_dat      out  8  latched byte, constant for the whole frame
//  o_tx_done     out  1  one-cycle pulse after stop bit completes
// BEHAVIOUR
//  Reset (async): state=IDLE, o_rs232_busy=0, o_ctrl_cnt=0, o_tx_dat=0,
//   o_tx_done=0, baud counter=0; o_tx_rdy=1 (decoded from IDLE).
//  All outputs registered except o_tx_rdy (= state==IDLE).
//  FSM: IDLE, SEND.
//   IDLE: on transfer edge -> SEND; same edge: o_tx_dat<=i_tx_dat, busy<=1,
//    ctrl_cnt<=0, baud_cnt<=0. No transfer -> stay, outputs hold.
//   SEND: baud_cnt counts 0..BAUD_DIV-1 per bit. At baud_cnt==BAUD_DIV-1:
//    baud_cnt<=0; if ctrl_cnt<9 ctrl_cnt<=ctrl_cnt+1; if ctrl_cnt==9 ->
//    IDLE, busy<=0, ctrl_cnt<=0, o_tx_done<=1.
//  Latency: busy rises 1 clk after transfer edge; busy high exactly 10*BAUD_DIV
//   clks; each ctrl_cnt value held exactly BAUD_DIV clks.
//  o_tx_done high exactly 1 clk, coincident with first IDLE cycle (rdy=1).
//  Back-to-back: req held high -> next transfer occurs in that done cycle;
//   busy therefore low for exactly 1 clk between frames (downstream edge
//   detector requires >=1 low clk; guaranteed).
//  i_tx_req while SEND ignored (not queued); i_tx_dat changes in SEND have no
//   effect on o_tx_dat.
//  ctrl_cnt never exceeds 9; baud_cnt never exceeds BAUD_DIV-1.
//  rst_n asserted mid-frame: all outputs return to reset values immediately;
//   no done pulse; partial frame abandoned; after release block is in IDLE.
//  Request during reset ignored; first transfer possible on first edge after release.
// TESTING  (sim params CLK_FREQ=1_000_000, BAUD=100_000 -> BAUD_DIV=10)
//  1 reset, no req -> busy=0, ctrl_cnt=0, o_tx_dat=0x00, done=0, rdy=1 steady.
//  2 req 1 clk with 0xA5 -> busy high 100 clks, ctrl_cnt 0..9 each 10 clks,
//    o_tx_dat=0xA5 throughout, done 1-clk pulse on first clk after busy falls.
//  3 req held, 0x55 then 0x0F at done cycle -> busy low exactly 1 clk between
//    frames; second frame o_tx_dat=0x0F; two done pulses 101 clks apart.
//  4 req pulses and i_tx_dat toggles during frame of 0x3C -> ignored; o_tx_dat
//    stays 0x3C; only one done pulse.
//  5 rst_n low at ctrl_cnt=4 -> busy/ctrl_cnt/o_tx_dat clear asynchronously, no
//    done; after release, req 0x81 -> clean frame from ctrl_cnt=0.
//  6 with downstream pin-mux attached, send 0xA5 -> sampled line at bit centres
//    = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); idle line 1.

Source files
------------

// File: rtl/rs232_tx_ctrl.sv
// RS-232 transmitter timing/control stage: byte handshake, baud timing,
// frame-active flag, bit index and held byte for the downstream bit-mux.
module rs232_tx_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    input  logic       i_tx_req,
    input  logic [7:0] i_tx_dat,
    output logic       o_tx_rdy,
    output logic       o_rs232_busy,
    output logic [3:0] o_ctrl_cnt,
    output logic [7:0] o_tx_dat,
    output logic       o_tx_done
);

    localparam int          BAUD_DIV  = CLK_FREQ / BAUD;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_BIT  = 4'd9;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      state, state_d;
    logic [15:0] baud_cnt, baud_cnt_d;
    logic [3:0]  ctrl_cnt_d;
    logic [7:0]  tx_dat_d;
    logic        busy_d;
    logic        done_d;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            o_ctrl_cnt   <= '0;
            o_tx_dat     <= '0;
            o_rs232_busy <= 1'b0;
            o_tx_done    <= 1'b0;
        end else begin
            state        <= state_d;
            baud_cnt     <= baud_cnt_d;
            o_ctrl_cnt   <= ctrl_cnt_d;
            o_tx_dat     <= tx_dat_d;
            o_rs232_busy <= busy_d;
            o_tx_done    <= done_d;
        end
    end

    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        ctrl_cnt_d = o_ctrl_cnt;
        tx_dat_d   = o_tx_dat;
        busy_d     = o_rs232_busy;
        done_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_tx_req) begin
                    state_d    = SEND;
                    tx_dat_d   = i_tx_dat;
                    busy_d     = 1'b1;
                    ctrl_cnt_d = '0;
                    baud_cnt_d = '0;
                end
            end
            SEND: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    // Stop bit finished: frame ends, done coincides with IDLE
                    if (o_ctrl_cnt == LAST_BIT) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        ctrl_cnt_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        ctrl_cnt_d = o_ctrl_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + 16'd1;
                end
            end
        endcase
    end

    assign o_tx_rdy = (state == IDLE);

endmodule

// File: tb/tb_rs232_tx_ctrl.sv
// Self-checking bench for rs232_tx_ctrl (BAUD_DIV = 10).
// Scoreboard of sent bytes is popped on each done pulse.
module tb_rs232_tx_ctrl;

    localparam int T = 10;

    logic       clk_ref = 1'b0;
    logic       rst_n;
    logic       i_tx_req;
    logic [7:0] i_tx_dat;
    logic       o_tx_rdy;
    logic       o_rs232_busy;
    logic [3:0] o_ctrl_cnt;
    logic [7:0] o_tx_dat;
    logic       o_tx_done;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q[$];
    time last_done;

    rs232_tx_ctrl #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk_ref     (clk_ref),
        .rst_n       (rst_n),
        .i_tx_req    (i_tx_req),
        .i_tx_dat    (i_tx_dat),
        .o_tx_rdy    (o_tx_rdy),
        .o_rs232_busy(o_rs232_busy),
        .o_ctrl_cnt  (o_ctrl_cnt),
        .o_tx_dat    (o_tx_dat),
        .o_tx_done   (o_tx_done)
    );

    always #(T/2) clk_ref = ~clk_ref;

    // Downstream pin-mux model: start 0, data LSB first, stop 1, idle 1
    function automatic logic line_model();
        int idx;
        if (!o_rs232_busy) return 1'b1;
        if (o_ctrl_cnt == 4'd0) return 1'b0;
        if (o_ctrl_cnt == 4'd9) return 1'b1;
        idx = int'(o_ctrl_cnt) - 1;
        return o_tx_dat[idx];
    endfunction

    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] b);
        i_tx_req = 1'b1;
        i_tx_dat = b;
        sb_q.push_back(b);
        step();
    endtask

    // Entered one clk after the transfer edge; leaves in the done cycle
    task automatic check_frame(input bit noise, input bit hold);
        logic [7:0] exp_b;
        logic [7:0] got;
        exp_b = (sb_q.size() != 0) ? sb_q[0] : 8'hxx;
        if (!hold && !noise) i_tx_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tests++;
            if ({o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done, o_tx_rdy}
                !== {1'b1, 4'(k / 10), exp_b, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL frame k=%0d busy=%b cnt=%0d dat=%h done=%b rdy=%b want cnt=%0d dat=%h",
                         k, o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done,
                         o_tx_rdy, k / 10, exp_b);
            end
            if (noise && k < 95) begin
                i_tx_req = 1'($urandom_range(0, 1));
                i_tx_dat = 8'($urandom);
            end else if (noise) begin
                i_tx_req = 1'b0;
            end
            if (k == 99) i_tx_req = hold;
            step();
        end
        tests++;
        if ({o_tx_done, o_rs232_busy, o_tx_rdy} !== 3'b101) begin
            fails++;
            $display("FAIL done_cycle done=%b busy=%b rdy=%b want 1 0 1",
                     o_tx_done, o_rs232_busy, o_tx_rdy);
        end
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty got done with no byte pending");
        end else begin
            got = sb_q.pop_front();
            if (o_tx_dat !== got) begin
                fails++;
                $display("FAIL done_data got %h want %h", o_tx_dat, got);
            end
        end
        last_done = $time;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            tests++;
            if ({o_rs232_busy, o_tx_done, o_tx_rdy} !== 3'b001) begin
                fails++;
                $display("FAIL %s busy=%b done=%b rdy=%b want 0 0 1",
                         name, o_rs232_busy, o_tx_done, o_tx_rdy);
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        i_tx_req = 1'b0;
        i_tx_dat = 8'h00;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) rst_n = 1'b1;
            tests++;
            if ({o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done, o_tx_rdy}
                !== {1'b0, 4'd0, 8'h00, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset k=%0d busy=%b cnt=%0d dat=%h done=%b rdy=%b",
                         k, o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done,
                         o_tx_rdy);
            end
            step();
        end
    endtask

    task automatic test_single();
        start_tx(8'hA5);
        check_frame(1'b0, 1'b0);
        step();
        check_idle("single_after", 3);
    endtask

    task automatic test_back_to_back();
        time t1;
        start_tx(8'h55);
        check_frame(1'b0, 1'b1);
        t1 = last_done;
        i_tx_dat = 8'h0F;
        sb_q.push_back(8'h0F);
        step();
        tests++;
        if (o_rs232_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap busy=%b want 1", o_rs232_busy);
        end
        check_frame(1'b0, 1'b0);
        tests++;
        if (last_done - t1 != 101 * T) begin
            fails++;
            $display("FAIL b2b_spacing got %0t want %0t", last_done - t1, 101 * T);
        end
        step();
        check_idle("b2b_after", 3);
    endtask

    task automatic test_ignore();
        start_tx(8'h3C);
        check_frame(1'b1, 1'b0);
        step();
        check_idle("ignore_after", 20);
    endtask

    task automatic test_reset_mid();
        start_tx(8'h77);
        i_tx_req = 1'b0;
        repeat (42) step();
        tests++;
        if (o_ctrl_cnt !== 4'd4) begin
            fails++;
            $display("FAIL mid_cnt got %0d want 4", o_ctrl_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done, o_tx_rdy}
            !== {1'b0, 4'd0, 8'h00, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL async_clear busy=%b cnt=%0d dat=%h done=%b rdy=%b",
                     o_rs232_busy, o_ctrl_cnt, o_tx_dat, o_tx_done, o_tx_rdy);
        end
        sb_q.delete();
        i_tx_req = 1'b1;
        i_tx_dat = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if ({o_rs232_busy, o_tx_dat} !== 9'h000) begin
                fails++;
                $display("FAIL req_in_reset busy=%b dat=%h want 0 00",
                         o_rs232_busy, o_tx_dat);
            end
        end
        i_tx_req = 1'b0;
        rst_n    = 1'b1;
        step();
        check_idle("post_reset", 3);
        start_tx(8'h81);
        check_frame(1'b0, 1'b0);
        step();
    endtask

    task automatic test_pin_mux();
        logic [9:0] exp_line;
        exp_line = 10'b1101001010;
        tests++;
        if (line_model() !== 1'b1) begin
            fails++;
            $display("FAIL idle_line got %b want 1", line_model());
        end
        start_tx(8'hA5);
        i_tx_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k % 10 == 5) begin
                tests++;
                if (line_model() !== exp_line[k / 10]) begin
                    fails++;
                    $display("FAIL line bit=%0d got %b want %b",
                             k / 10, line_model(), exp_line[k / 10]);
                end
            end
            step();
        end
        tests++;
        if (o_tx_done !== 1'b1 || sb_q.size() == 0) begin
            fails++;
            $display("FAIL pin_done done=%b pending=%0d", o_tx_done, sb_q.size());
        end else begin
            void'(sb_q.pop_front());
        end
        step();
        tests++;
        if (line_model() !== 1'b1) begin
            fails++;
            $display("FAIL idle_line_after got %b want 1", line_model());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_pin_mux();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
